// File: rtl/program_loader_pkg.sv
// Shared constants and state encodings for the serial program loader.
package program_loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         PROGRAM_BYTES     = 16;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    LOAD      = 2'd1,
    CHECKSUM  = 2'd2,
    RUN       = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/program_loader_uart_rx.sv
// 8N1 receiver: 2-flop synchronizer, mid-bit sampling, LSB first.
// valid_o / frame_err_o pulse one cycle after the stop-bit sample; no backpressure.
module program_loader_uart_rx
  import program_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk_i,
  input  logic       reset,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);

  logic [1:0]    sync_q;
  logic          rx_s;
  logic          rx_prev_q;
  rx_state_t     st_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk_i) begin
    if (reset) begin
      sync_q      <= 2'b11;
      rx_prev_q   <= 1'b1;
      st_q        <= RX_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], rx_i};
      rx_prev_q   <= rx_s;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      case (st_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_s) begin
            st_q  <= RX_START;
            cnt_q <= '0;
          end
        end
        RX_START: begin
          // A start bit that is high again at half-bit was only a glitch.
          if (cnt_q == HALF_M1) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            st_q      <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q == LAST) begin
            cnt_q     <= '0;
            shift_q   <= {rx_s, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) st_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_q == LAST) begin
            cnt_q <= '0;
            st_q  <= RX_IDLE;
            if (rx_s) begin
              valid_o <= 1'b1;
              data_o  <= shift_q;
            end else begin
              frame_err_o <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: st_q <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/program_loader.sv
// UART bootloader: sync byte, 16 program bytes, checksum; writes RAM, gates CPU reset.
// RAM write 1 cycle after byte valid; CPU released 2 cycles after good checksum; no backpressure.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int         CLKS_PER_BIT   = 104,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter int         START_RUNNING  = 1,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
  input  logic       clk_i,
  input  logic       reset,
  input  logic       uart_rx_i,
  output logic       ram_we_o,
  output logic [3:0] ram_addr_o,
  output logic [7:0] ram_data_o,
  output logic       cpu_reset_o,
  output logic       load_done_o,
  output logic       load_error_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    LAST_BYTE    = 4'(PROGRAM_BYTES - 1);

  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_frame_err;
  state_t        state_q;
  logic          boot_q;
  logic [3:0]    byte_cnt_q;
  logic [7:0]    acc_q;
  logic [TW-1:0] timer_q;
  logic          timeout;
  logic          is_sync;

  program_loader_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_rx (
    .clk_i       (clk_i),
    .reset       (reset),
    .rx_i        (uart_rx_i),
    .data_o      (rx_data),
    .valid_o     (rx_valid),
    .frame_err_o (rx_frame_err)
  );

  assign timeout = (timer_q == TIMEOUT_LAST);
  assign is_sync = rx_valid && (rx_data == SYNC_BYTE);

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q      <= WAIT_SYNC;
      boot_q       <= 1'b1;
      cpu_reset_o  <= 1'b1;
      ram_we_o     <= 1'b0;
      ram_addr_o   <= '0;
      ram_data_o   <= '0;
      load_done_o  <= 1'b0;
      load_error_o <= 1'b0;
      byte_cnt_q   <= '0;
      acc_q        <= '0;
      timer_q      <= '0;
    end else begin
      boot_q   <= 1'b0;
      ram_we_o <= 1'b0;
      if (boot_q) cpu_reset_o <= (START_RUNNING == 0);

      // Inter-byte gap timer only matters while a frame is in flight.
      if (rx_valid || state_q == WAIT_SYNC || state_q == RUN) timer_q <= '0;
      else                                                    timer_q <= timer_q + 1'b1;

      case (state_q)
        WAIT_SYNC, RUN: begin
          if (state_q == RUN) cpu_reset_o <= 1'b0;
          if (is_sync) begin
            state_q      <= LOAD;
            cpu_reset_o  <= 1'b1;
            byte_cnt_q   <= '0;
            acc_q        <= '0;
            load_done_o  <= 1'b0;
            load_error_o <= 1'b0;
          end
        end
        LOAD: begin
          if (rx_valid) begin
            ram_we_o   <= 1'b1;
            ram_addr_o <= byte_cnt_q;
            ram_data_o <= rx_data;
            acc_q      <= acc_q + rx_data;
            byte_cnt_q <= byte_cnt_q + 1'b1;
            if (byte_cnt_q == LAST_BYTE) state_q <= CHECKSUM;
          end else if (rx_frame_err || timeout) begin
            load_error_o <= 1'b1;
            state_q      <= WAIT_SYNC;
          end
        end
        CHECKSUM: begin
          if (rx_valid) begin
            if (rx_data == acc_q) begin
              load_done_o <= 1'b1;
              state_q     <= RUN;
            end else begin
              load_error_o <= 1'b1;
              state_q      <= WAIT_SYNC;
            end
          end else if (rx_frame_err || timeout) begin
            load_error_o <= 1'b1;
            state_q      <= WAIT_SYNC;
          end
        end
        default: state_q <= WAIT_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a write scoreboard and immediate-assertion checks.
module tb_program_loader;
  import program_loader_pkg::*;

  localparam int CPB = 4;
  localparam int TO  = 200;

  logic       clk_i = 1'b0;
  logic       reset = 1'b1;
  logic       uart_rx_i = 1'b1;
  logic       ram_we_o;
  logic [3:0] ram_addr_o;
  logic [7:0] ram_data_o;
  logic       cpu_reset_o;
  logic       load_done_o;
  logic       load_error_o;

  program_loader #(
    .CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TO), .START_RUNNING(1), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk_i(clk_i), .reset(reset), .uart_rx_i(uart_rx_i),
    .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
    .cpu_reset_o(cpu_reset_o), .load_done_o(load_done_o), .load_error_o(load_error_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_wr  = 0;
  int n_vld = 0;
  int n_ferr = 0;
  int last_vld_cyc = 0;
  int fall_cyc = 0;
  int rise_cyc = 0;
  int err_cyc  = 0;
  logic prev_we = 1'b0;
  logic prev_cpu = 1'b1;
  logic prev_err = 1'b0;
  logic [12:0] exp_q[$];
  logic [7:0]  prog[16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // Output monitor: pops expected RAM writes and timestamps control edges.
  always @(negedge clk_i) begin
    logic [12:0] exp;
    if (!reset) begin
      if (dut.rx_valid) begin
        last_vld_cyc = cyc;
        n_vld++;
      end
      if (dut.rx_frame_err) n_ferr++;
      if (prev_cpu && !cpu_reset_o) fall_cyc = cyc;
      if (!prev_cpu && cpu_reset_o) rise_cyc = cyc;
      if (!prev_err && load_error_o) err_cyc = cyc;
      if (ram_we_o) begin
        check("we_single_cycle", 32'(prev_we), 32'(0));
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 13'h0;
        check("wr_addr_data", 32'({1'b1, ram_addr_o, ram_data_o}), 32'(exp));
        n_wr++;
      end
    end
    prev_we  = ram_we_o;
    prev_cpu = cpu_reset_o;
    prev_err = load_error_o;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk_i);
    uart_rx_i = 1'b0;
    repeat (CPB) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = b[i];
      repeat (CPB) @(negedge clk_i);
    end
    uart_rx_i = stop;
    repeat (CPB) @(negedge clk_i);
    uart_rx_i = 1'b1;
    repeat (3) @(negedge clk_i);
  endtask

  task automatic send_body(input logic [7:0] cks);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({1'b1, 4'(i), prog[i]});
      send_byte(prog[i], 1'b1);
    end
    send_byte(cks, 1'b1);
  endtask

  function automatic logic [7:0] prog_sum();
    logic [7:0] s = 8'h00;
    for (int i = 0; i < 16; i++) s = s + prog[i];
    return s;
  endfunction

  task automatic wait_done();
    for (int i = 0; i < 100 && !load_done_o; i++) @(negedge clk_i);
    repeat (4) @(negedge clk_i);
  endtask

  task automatic wait_err();
    for (int i = 0; i < 100 && !load_error_o; i++) @(negedge clk_i);
    repeat (4) @(negedge clk_i);
  endtask

  initial begin
    int wr0, vld0, ferr0;

    // Reset behaviour
    reset = 1'b1;
    repeat (3) @(negedge clk_i);
    check("rst_cpu_reset", 32'(cpu_reset_o), 32'(1));
    check("rst_we", 32'(ram_we_o), 32'(0));
    check("rst_done", 32'(load_done_o), 32'(0));
    check("rst_err", 32'(load_error_o), 32'(0));
    reset = 1'b0;
    @(negedge clk_i);
    check("boot_cpu_released", 32'(cpu_reset_o), 32'(0));
    check("boot_state", 32'(dut.state_q), 32'(WAIT_SYNC));
    repeat (10) @(negedge clk_i);
    check("boot_no_writes", 32'(n_wr), 32'(0));

    // Good frame 0..15, checksum 0x78
    for (int i = 0; i < 16; i++) prog[i] = 8'(i);
    n_wr = 0;
    send_byte(8'hA5, 1'b1);
    check("load_holds_cpu", 32'(cpu_reset_o), 32'(1));
    send_body(8'h78);
    wait_done();
    check("good_done", 32'(load_done_o), 32'(1));
    check("good_err", 32'(load_error_o), 32'(0));
    check("good_cpu", 32'(cpu_reset_o), 32'(0));
    check("good_release_lat", 32'(fall_cyc - last_vld_cyc), 32'(2));
    check("good_nwr", 32'(n_wr), 32'(16));
    check("good_state", 32'(dut.state_q), 32'(RUN));

    // Same frame, bad checksum 0x77
    n_wr = 0;
    send_byte(8'hA5, 1'b1);
    send_body(8'h77);
    wait_err();
    check("badck_err", 32'(load_error_o), 32'(1));
    check("badck_done", 32'(load_done_o), 32'(0));
    check("badck_cpu", 32'(cpu_reset_o), 32'(1));
    check("badck_nwr", 32'(n_wr), 32'(16));
    check("badck_state", 32'(dut.state_q), 32'(WAIT_SYNC));

    // Timeout after sync plus 5 bytes
    n_wr = 0;
    send_byte(8'hA5, 1'b1);
    check("to_err_cleared", 32'(load_error_o), 32'(0));
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({1'b1, 4'(i), 8'(8'h40 + i)});
      send_byte(8'(8'h40 + i), 1'b1);
    end
    repeat (150) @(negedge clk_i);
    check("to_not_early", 32'(load_error_o), 32'(0));
    check("to_still_load", 32'(dut.state_q), 32'(LOAD));
    wait_err();
    check("to_err", 32'(load_error_o), 32'(1));
    check("to_cpu", 32'(cpu_reset_o), 32'(1));
    check("to_window", 32'((err_cyc - last_vld_cyc) >= 199 && (err_cyc - last_vld_cyc) <= 202), 32'(1));
    check("to_nwr", 32'(n_wr), 32'(5));

    // Recovery with a full valid frame
    for (int i = 0; i < 16; i++) prog[i] = 8'(i * 7 + 3);
    send_byte(8'hA5, 1'b1);
    send_body(prog_sum());
    wait_done();
    check("rec_done", 32'(load_done_o), 32'(1));
    check("rec_err", 32'(load_error_o), 32'(0));
    check("rec_cpu", 32'(cpu_reset_o), 32'(0));

    // RUN: non-sync byte ignored, then hot reload with 0xA5 as data
    wr0 = n_wr;
    send_byte(8'h3C, 1'b1);
    repeat (5) @(negedge clk_i);
    check("run_ignore_cpu", 32'(cpu_reset_o), 32'(0));
    check("run_ignore_nwr", 32'(n_wr), 32'(wr0));
    check("run_ignore_state", 32'(dut.state_q), 32'(RUN));
    send_byte(8'hA5, 1'b1);
    check("hot_cpu", 32'(cpu_reset_o), 32'(1));
    check("hot_rise_lat", 32'(rise_cyc - last_vld_cyc), 32'(1));
    for (int i = 0; i < 16; i++) prog[i] = 8'(8'h10 + i * 5);
    prog[3] = 8'hA5;
    send_body(prog_sum());
    wait_done();
    check("hot_done", 32'(load_done_o), 32'(1));
    check("hot_nwr", 32'(n_wr - wr0), 32'(16));

    // Framing error during LOAD
    wr0 = n_wr;
    ferr0 = n_ferr;
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({1'b1, 4'(i), 8'(8'hC0 + i)});
      send_byte(8'(8'hC0 + i), 1'b1);
    end
    send_byte(8'h5A, 1'b0);
    repeat (5) @(negedge clk_i);
    check("ferr_err", 32'(load_error_o), 32'(1));
    check("ferr_seen", 32'(n_ferr - ferr0), 32'(1));
    check("ferr_nwr", 32'(n_wr - wr0), 32'(2));
    check("ferr_cpu", 32'(cpu_reset_o), 32'(1));
    check("ferr_state", 32'(dut.state_q), 32'(WAIT_SYNC));

    // One-cycle glitch on an idle line
    vld0 = n_vld;
    ferr0 = n_ferr;
    @(negedge clk_i);
    uart_rx_i = 1'b0;
    @(negedge clk_i);
    uart_rx_i = 1'b1;
    repeat (60) @(negedge clk_i);
    check("glitch_vld", 32'(n_vld), 32'(vld0));
    check("glitch_ferr", 32'(n_ferr), 32'(ferr0));
    check("scoreboard_empty", 32'(exp_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case a wait never resolves.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
